// File: rtl/shifter_pkg.sv
// Shared types for the multi-cycle shift engine: mode encoding, FSM states
// and the reserved-mode predicate.
package shifter_pkg;

    typedef enum logic [2:0] {
        MODE_SLL = 3'd0,
        MODE_SRL = 3'd1,
        MODE_SRA = 3'd2,
        MODE_ROL = 3'd3,
        MODE_ROR = 3'd4
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned MODE_W = 3;

    // Encodings 5..7 carry no operation; the operand passes through untouched.
    function automatic logic mode_is_reserved(input logic [MODE_W-1:0] mode);
        return (mode > 3'd4);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational one-bit shift/rotate step; bit_o is the bit leaving the word.
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]  value_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [WIDTH-1:0]  value_o,
    output logic              bit_o
);

    // Select the single-position step for the captured mode.
    always_comb begin
        value_o = value_i;
        bit_o   = 1'b0;
        case (mode_i)
            MODE_SLL: begin
                value_o = {value_i[WIDTH-2:0], 1'b0};
                bit_o   = value_i[WIDTH-1];
            end
            MODE_SRL: begin
                value_o = {1'b0, value_i[WIDTH-1:1]};
                bit_o   = value_i[0];
            end
            MODE_SRA: begin
                value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
                bit_o   = value_i[0];
            end
            MODE_ROL: begin
                value_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
                bit_o   = value_i[WIDTH-1];
            end
            MODE_ROR: begin
                value_o = {value_i[0], value_i[WIDTH-1:1]};
                bit_o   = value_i[0];
            end
            default: begin
                value_o = value_i;
                bit_o   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_engine.sv
// Multi-cycle shifter, one bit per clock, valid/ready on both sides.
// Optional SHIFTER_FLAGS_EN adds out_carry / out_zero result flags.
module shift_engine
    import shifter_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [AW-1:0]     in_amt,
    input  logic [MODE_W-1:0] in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              busy
`ifdef SHIFTER_FLAGS_EN
    ,
    output logic              out_carry,
    output logic              out_zero
`endif
);

    localparam logic [AW-1:0] CNT_ONE = AW'(1);

    state_e              state_q;
    logic [WIDTH-1:0]    data_q;
    logic [AW-1:0]       cnt_q;
    logic [MODE_W-1:0]   mode_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic                busy_q;
    logic [WIDTH-1:0]    step_data_d;
    logic                step_bit_d;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .value_i (data_q),
        .mode_i  (mode_q),
        .value_o (step_data_d),
        .bit_o   (step_bit_d)
    );

    // Control FSM with registered handshake outputs and working register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            data_q      <= {WIDTH{1'b0}};
            cnt_q       <= {AW{1'b0}};
            mode_q      <= {MODE_W{1'b0}};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q     <= in_data;
                        cnt_q      <= in_amt;
                        mode_q     <= in_mode;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        if ((in_amt != {AW{1'b0}}) && !mode_is_reserved(in_mode)) begin
                            state_q <= ST_SHIFT;
                        end else begin
                            state_q     <= ST_DONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= step_data_d;
                    cnt_q  <= cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = data_q;
    assign busy      = busy_q;

`ifdef SHIFTER_FLAGS_EN
    logic carry_q;
    logic zero_q;

    // Track the last bit shifted out and the zero status alongside data_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        carry_q <= 1'b0;
                        zero_q  <= (in_data == {WIDTH{1'b0}});
                    end
                end
                ST_SHIFT: begin
                    carry_q <= step_bit_d;
                    zero_q  <= (step_data_d == {WIDTH{1'b0}});
                end
                default: begin
                    carry_q <= carry_q;
                    zero_q  <= zero_q;
                end
            endcase
        end
    end

    assign out_carry = carry_q;
    assign out_zero  = zero_q;
`else
    logic unused_step_bit;
    assign unused_step_bit = step_bit_d;
`endif

endmodule

// File: tb/tb_shift_engine.sv
// Directed self-checking bench for shift_engine (WIDTH=8).
module tb_shift_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic [2:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
`ifdef SHIFTER_FLAGS_EN
    logic       out_carry;
    logic       out_zero;
`endif

    int tests = 0;
    int fails = 0;

    shift_engine #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
`ifdef SHIFTER_FLAGS_EN
        ,
        .out_carry (out_carry),
        .out_zero  (out_zero)
`endif
    );

    always #5 clk = ~clk;

    // Present a command for one edge, scramble inputs, then count edges until out_valid.
    task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m,
                         output int lat);
        @(negedge clk);
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~d;
        in_amt   = ~a;
        in_mode  = 3'd6;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_data = 8'h00; in_amt = 3'd0; in_mode = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef SHIFTER_FLAGS_EN
        tests++; if (out_carry !== 1'b0 || out_zero !== 1'b0) begin fails++; $display("FAIL reset_flags: got %b%b want 00", out_carry, out_zero); end
`endif
    endtask

    task automatic test_shifts();
        int lat;
        issue(8'h01, 3'd3, 3'd0, lat);
        tests++; if (lat !== 4) begin fails++; $display("FAIL sll_latency: got %0d want 4", lat); end
        tests++; if (out_data !== 8'h08) begin fails++; $display("FAIL sll_data: got %h want 08", out_data); end
        tests++; if (busy !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("FAIL sll_busy: got busy=%b rdy=%b want 1/0", busy, in_ready); end
`ifdef SHIFTER_FLAGS_EN
        tests++; if (out_carry !== 1'b0) begin fails++; $display("FAIL sll_carry: got %b want 0", out_carry); end
`endif
        drain();
        issue(8'h90, 3'd2, 3'd2, lat);
        tests++; if (lat !== 3) begin fails++; $display("FAIL sra_latency: got %0d want 3", lat); end
        tests++; if (out_data !== 8'hE4) begin fails++; $display("FAIL sra_data: got %h want E4", out_data); end
`ifdef SHIFTER_FLAGS_EN
        tests++; if (out_carry !== 1'b0) begin fails++; $display("FAIL sra_carry: got %b want 0", out_carry); end
`endif
        drain();
        issue(8'h90, 3'd2, 3'd1, lat);
        tests++; if (out_data !== 8'h24) begin fails++; $display("FAIL srl_data: got %h want 24", out_data); end
        drain();
    endtask

    task automatic test_rotate();
        int lat;
        issue(8'h81, 3'd1, 3'd3, lat);
        tests++; if (out_data !== 8'h03) begin fails++; $display("FAIL rol_data: got %h want 03", out_data); end
`ifdef SHIFTER_FLAGS_EN
        tests++; if (out_carry !== 1'b1) begin fails++; $display("FAIL rol_carry: got %b want 1", out_carry); end
`endif
        drain();
        issue(8'h81, 3'd7, 3'd4, lat);
        tests++; if (lat !== 8) begin fails++; $display("FAIL ror_latency: got %0d want 8", lat); end
        tests++; if (out_data !== 8'h03) begin fails++; $display("FAIL ror_data: got %h want 03", out_data); end
`ifdef SHIFTER_FLAGS_EN
        tests++; if (out_carry !== 1'b0) begin fails++; $display("FAIL ror_carry: got %b want 0", out_carry); end
`endif
        drain();
        issue(8'h80, 3'd1, 3'd0, lat);
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL sll_to_zero: got %h want 00", out_data); end
`ifdef SHIFTER_FLAGS_EN
        tests++; if (out_zero !== 1'b1 || out_carry !== 1'b1) begin fails++; $display("FAIL zero_flags: got z=%b c=%b want 1/1", out_zero, out_carry); end
`endif
        drain();
    endtask

    task automatic test_passthrough();
        int lat;
        issue(8'h5A, 3'd0, 3'd0, lat);
        tests++; if (lat !== 1) begin fails++; $display("FAIL amt0_latency: got %0d want 1", lat); end
        tests++; if (out_data !== 8'h5A) begin fails++; $display("FAIL amt0_data: got %h want 5A", out_data); end
`ifdef SHIFTER_FLAGS_EN
        tests++; if (out_carry !== 1'b0 || out_zero !== 1'b0) begin fails++; $display("FAIL amt0_flags: got c=%b z=%b want 0/0", out_carry, out_zero); end
`endif
        drain();
        issue(8'h5A, 3'd5, 3'd6, lat);
        tests++; if (lat !== 1) begin fails++; $display("FAIL rsvd_latency: got %0d want 1", lat); end
        tests++; if (out_data !== 8'h5A) begin fails++; $display("FAIL rsvd_data: got %h want 5A", out_data); end
`ifdef SHIFTER_FLAGS_EN
        tests++; if (out_carry !== 1'b0 || out_zero !== 1'b0) begin fails++; $display("FAIL rsvd_flags: got c=%b z=%b want 0/0", out_carry, out_zero); end
`endif
        drain();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        issue(8'h01, 3'd3, 3'd0, lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_data = 8'hFF; in_amt = 3'd1; in_mode = 3'd1; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== 8'h08 || in_ready !== 1'b0) bad++;
        end
        in_valid = 1'b0;
        tests++; if (bad !== 0) begin fails++; $display("FAIL hold_done: %0d bad cycles, last v=%b d=%h rdy=%b want 1/08/0", bad, out_valid, out_data, in_ready); end
        drain();
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL drain_idle: got rdy=%b v=%b want 1/0", in_ready, out_valid); end
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0 || out_data !== 8'h08) begin fails++; $display("FAIL no_capture: got busy=%b d=%h want 0/08", busy, out_data); end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        in_data = 8'hFF; in_amt = 3'd7; in_mode = 3'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 8'h00 || busy !== 1'b0)
            begin fails++; $display("FAIL reset_mid: got rdy=%b v=%b d=%h busy=%b want 1/0/00/0", in_ready, out_valid, out_data, busy); end
        issue(8'h80, 3'd7, 3'd1, lat);
        tests++; if (lat !== 8 || out_data !== 8'h01) begin fails++; $display("FAIL post_reset_srl: got lat=%0d d=%h want 8/01", lat, out_data); end
        drain();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(8'h11, 3'd1, 3'd0, lat);
        tests++; if (out_data !== 8'h22) begin fails++; $display("FAIL b2b_first: got %h want 22", out_data); end
        in_data = 8'h03; in_amt = 3'd2; in_mode = 3'd0; in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL b2b_no_same_cycle: got rdy=%b v=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
        @(negedge clk);
        in_valid = 1'b0;
        tests++; if (in_ready !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: got rdy=%b busy=%b want 0/1", in_ready, busy); end
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        tests++; if (lat !== 3 || out_data !== 8'h0C) begin fails++; $display("FAIL b2b_second: got lat=%0d d=%h want 3/0C", lat, out_data); end
        drain();
    endtask

    initial begin
        test_reset();
        test_shifts();
        test_rotate();
        test_passthrough();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
